// File: rtl/rob_pkg.sv
// rob_pkg
// Definitions shared by the reorder buffer and its commit selector.
//   op_t    : op class the dispatcher tags each entry with
//   XLEN    : width of pc and result fields
//   REG_W   : width of an architectural register number
//   TYPE_W  : width of the op class field
package rob_pkg;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int TYPE_W = 3;

    typedef enum logic [TYPE_W-1:0] {
        EMPTY  = 3'd0,
        REG    = 3'd1,
        BRANCH = 3'd2,
        JALR   = 3'd3,
        STORE  = 3'd4
    } op_t;

endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select
// Combinational choice of which entries retire this cycle, in order from head.
//   head    : ROB index of the oldest entry
//   busy    : per-entry allocated flag
//   ready   : per-entry result-known flag
//   types   : per-entry op class, flattened TYPE_W bits per entry
//   retire  : per-slot retire mask; slot k refers to entry head+k
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int ROB_W    = 3,
    parameter int COMMIT_W = 2
) (
    input  logic [ROB_W-1:0]               head,
    input  logic [(1<<ROB_W)-1:0]          busy,
    input  logic [(1<<ROB_W)-1:0]          ready,
    input  logic [(1<<ROB_W)*TYPE_W-1:0]   types,
    output logic [COMMIT_W-1:0]            retire
);

    logic             chain;
    logic [ROB_W-1:0] idx;
    op_t              slot_type;

    // The mask is contiguous from slot 0: once a slot cannot retire, or it
    // retires anything with side effects beyond a register write, the group
    // stops so branches, jumps and stores are always alone at the head.
    always_comb begin
        retire    = '0;
        chain     = 1'b1;
        idx       = '0;
        slot_type = EMPTY;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx       = head + ROB_W'(k);
            slot_type = op_t'(types[idx*TYPE_W +: TYPE_W]);
            if (chain && busy[idx] && ready[idx] && (k == 0 || slot_type == REG)) begin
                retire[k] = 1'b1;
                if (slot_type != REG) begin
                    chain = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit
// Reorder buffer with CDB_N writeback ports and up to COMMIT_W in-order retirements per cycle.
//   clk_in, rst_in, rdy_in       : clock, synchronous active-high reset, global stall (0 = hold)
//   alloc_*                      : dispatcher allocation request; alloc_idx/full report tail and fullness
//   cdb_en/cdb_idx/cdb_data      : flattened writeback ports
//   rf_en/rf_reg/rf_idx/rf_data  : flattened per-slot register file commit
//   store_commit_en/_idx         : head store released to the LSB
//   bp_en/bp_pc/bp_taken         : resolved branch outcome to the predictor
//   redirect_en/redirect_pc      : fetch redirection on mispredict or JALR
//   flush                        : one-cycle pipeline-wide clear
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int ROB_W    = 3,
    parameter int CDB_N    = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      alloc_en,
    input  logic [TYPE_W-1:0]         alloc_type,
    input  logic [REG_W-1:0]          alloc_rd,
    input  logic [XLEN-1:0]           alloc_pc,
    input  logic [XLEN-1:0]           alloc_alt_pc,
    input  logic                      alloc_pred,
    input  logic                      alloc_ready,
    input  logic [XLEN-1:0]           alloc_data,
    output logic [ROB_W-1:0]          alloc_idx,
    output logic                      full,
    input  logic [CDB_N-1:0]          cdb_en,
    input  logic [CDB_N*ROB_W-1:0]    cdb_idx,
    input  logic [CDB_N*XLEN-1:0]     cdb_data,
    output logic [COMMIT_W-1:0]       rf_en,
    output logic [COMMIT_W*REG_W-1:0] rf_reg,
    output logic [COMMIT_W*ROB_W-1:0] rf_idx,
    output logic [COMMIT_W*XLEN-1:0]  rf_data,
    output logic                      store_commit_en,
    output logic [ROB_W-1:0]          store_commit_idx,
    output logic                      bp_en,
    output logic [XLEN-1:0]           bp_pc,
    output logic                      bp_taken,
    output logic                      redirect_en,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      flush
);

    localparam int ROB_SIZE = 1 << ROB_W;
    localparam int CNT_W    = ROB_W + 1;

    logic [ROB_W-1:0]         head;
    logic [ROB_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic [ROB_SIZE-1:0]      busy;
    logic [ROB_SIZE-1:0]      ready;

    op_t                      entry_type   [ROB_SIZE];
    logic [REG_W-1:0]         entry_rd     [ROB_SIZE];
    logic [XLEN-1:0]          entry_pc     [ROB_SIZE];
    logic [XLEN-1:0]          entry_alt_pc [ROB_SIZE];
    logic [XLEN-1:0]          entry_data   [ROB_SIZE];
    logic [ROB_SIZE-1:0]      entry_pred;

    logic [ROB_SIZE*TYPE_W-1:0] type_flat;
    logic [COMMIT_W-1:0]        retire;
    logic [ROB_W-1:0]           slot_idx [COMMIT_W];
    logic [ROB_W-1:0]           cdb_tgt  [CDB_N];
    logic [CNT_W-1:0]           retire_cnt;
    logic                       alloc_ok;

    assign alloc_idx = tail;
    // Fullness comes from the registered count, so a slot freed by this
    // cycle's commit cannot be reused until the next cycle.
    assign full      = (count == CNT_W'(ROB_SIZE));
    assign alloc_ok  = alloc_en && !full && !flush;

    always_comb begin
        type_flat = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            type_flat[i*TYPE_W +: TYPE_W] = entry_type[i];
        end
    end

    always_comb begin
        retire_cnt = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k] = head + ROB_W'(k);
            retire_cnt  = retire_cnt + CNT_W'(retire[k]);
        end
    end

    always_comb begin
        for (int p = 0; p < CDB_N; p++) begin
            cdb_tgt[p] = cdb_idx[p*ROB_W +: ROB_W];
        end
    end

    rob_commit_select #(
        .ROB_W    (ROB_W),
        .COMMIT_W (COMMIT_W)
    ) u_select (
        .head   (head),
        .busy   (busy),
        .ready  (ready),
        .types  (type_flat),
        .retire (retire)
    );

    // Entry payload needs no reset: busy/ready gate every read of it.
    // A CDB write only lands on a busy entry, so it never collides with the
    // allocation at tail.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush) begin
            for (int p = 0; p < CDB_N; p++) begin
                if (cdb_en[p] && busy[cdb_tgt[p]]) begin
                    entry_data[cdb_tgt[p]] <= cdb_data[p*XLEN +: XLEN];
                end
            end
            if (alloc_ok) begin
                entry_type[tail]   <= op_t'(alloc_type);
                entry_rd[tail]     <= alloc_rd;
                entry_pc[tail]     <= alloc_pc;
                entry_alt_pc[tail] <= alloc_alt_pc;
                entry_pred[tail]   <= alloc_pred;
                entry_data[tail]   <= alloc_data;
            end
        end
    end

    // Control state and registered commit outputs. The cycle in which flush
    // is high performs the clear itself; strobes drop and data outputs hold.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            rf_en            <= '0;
            rf_reg           <= '0;
            rf_idx           <= '0;
            rf_data          <= '0;
            store_commit_en  <= 1'b0;
            store_commit_idx <= '0;
            bp_en            <= 1'b0;
            bp_pc            <= '0;
            bp_taken         <= 1'b0;
            redirect_en      <= 1'b0;
            redirect_pc      <= '0;
            flush            <= 1'b0;
        end else if (rdy_in) begin
            rf_en           <= '0;
            store_commit_en <= 1'b0;
            bp_en           <= 1'b0;
            redirect_en     <= 1'b0;
            flush           <= 1'b0;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                for (int p = 0; p < CDB_N; p++) begin
                    if (cdb_en[p] && busy[cdb_tgt[p]]) begin
                        ready[cdb_tgt[p]] <= 1'b1;
                    end
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (retire[k]) begin
                        busy[slot_idx[k]]              <= 1'b0;
                        ready[slot_idx[k]]             <= 1'b0;
                        rf_reg[k*REG_W +: REG_W]       <= entry_rd[slot_idx[k]];
                        rf_idx[k*ROB_W +: ROB_W]       <= slot_idx[k];
                        case (entry_type[slot_idx[k]])
                            JALR: begin
                                rf_en[k]                 <= (entry_rd[slot_idx[k]] != '0);
                                rf_data[k*XLEN +: XLEN]  <= entry_pc[slot_idx[k]] + XLEN'(4);
                                redirect_en              <= 1'b1;
                                redirect_pc              <= {entry_data[slot_idx[k]][XLEN-1:1], 1'b0};
                                flush                    <= 1'b1;
                            end
                            BRANCH: begin
                                bp_en    <= 1'b1;
                                bp_pc    <= entry_pc[slot_idx[k]];
                                bp_taken <= entry_data[slot_idx[k]][0];
                                if (entry_data[slot_idx[k]][0] != entry_pred[slot_idx[k]]) begin
                                    redirect_en <= 1'b1;
                                    redirect_pc <= entry_alt_pc[slot_idx[k]];
                                    flush       <= 1'b1;
                                end
                            end
                            STORE: begin
                                store_commit_en  <= 1'b1;
                                store_commit_idx <= slot_idx[k];
                            end
                            default: begin
                                rf_en[k]                <= (entry_rd[slot_idx[k]] != '0);
                                rf_data[k*XLEN +: XLEN] <= entry_data[slot_idx[k]];
                            end
                        endcase
                    end
                end
                if (alloc_ok) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= alloc_ready;
                    tail        <= tail + 1'b1;
                end
                head  <= head + retire_cnt[ROB_W-1:0];
                count <= count + CNT_W'(alloc_ok) - retire_cnt;
            end
        end
    end

endmodule
